// File: rtl/mcycle_muldiv_if.sv
// Request/response bundle between the execute-stage control and the multi-cycle MUL/DIV unit.
interface mcycle_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;
    logic             DivByZero;
    logic [1:0]       Flags;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done, DivByZero, Flags
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done, DivByZero, Flags
    );
endinterface

// File: rtl/mcycle_muldiv.sv
// Bit-serial multiply (shift-add) / divide (restoring) unit; one operand bit per clock,
// signed ops run on magnitudes and get their sign fixed on the last iteration.
module mcycle_muldiv #(
    parameter int WIDTH = 32
) (
    input logic           CLK,
    input logic           RESET,
    mcycle_muldiv_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               accept, last, busy, done;
    logic [1:0]         op;
    logic               sgn1, sgn2;
    logic [WIDTH-1:0]   opb, dvd_raw;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   res1, res2;
    logic               dz;
    logic [1:0]         flags;

    // input magnitudes for the accepting edge
    logic             s1_in, s2_in;
    logic [WIDTH-1:0] mag1, mag2;

    // one iteration of each datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH:0]     div_sub;
    logic               div_ge;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quo_next;

    // sign-fixed final values
    logic               neg_q, neg_r, div_zero;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res1_fin, res2_fin;

    assign accept = bus.Start && (state != COMPUTE);
    assign last   = (state == COMPUTE) && (cnt == CW'(WIDTH-1));

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.Start) state_nxt = COMPUTE;
            COMPUTE: if (cnt == CW'(WIDTH-1)) state_nxt = FINISH;
            FINISH:  state_nxt = bus.Start ? COMPUTE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == COMPUTE);
        done = (state == FINISH);
    end

    always_comb begin
        s1_in = ~bus.MCycleOp[0] & bus.Operand1[WIDTH-1];
        s2_in = ~bus.MCycleOp[0] & bus.Operand2[WIDTH-1];
        mag1  = s1_in ? -bus.Operand1 : bus.Operand1;
        mag2  = s2_in ? -bus.Operand2 : bus.Operand2;
    end

    // MUL keeps {partial_hi, multiplier_lo} in acc; DIV uses acc low half as dividend/quotient
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {rem, acc[WIDTH-1]};
        div_ge    = div_shift >= {2'b00, opb};
        div_sub   = div_shift[WIDTH:0] - {1'b0, opb};
        rem_next  = div_ge ? div_sub : div_shift[WIDTH:0];
        quo_next  = {acc[WIDTH-2:0], div_ge};
    end

    always_comb begin
        neg_q    = ~op[0] & (sgn1 ^ sgn2);
        neg_r    = ~op[0] & sgn1;
        div_zero = op[1] & (opb == '0);
        prod_fix = neg_q ? -mul_next : mul_next;
        quo_fix  = neg_q ? -quo_next : quo_next;
        rem_fix  = neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
        if (!op[1]) begin
            res1_fin = prod_fix[WIDTH-1:0];
            res2_fin = prod_fix[2*WIDTH-1:WIDTH];
        end else if (div_zero) begin
            // divide-by-zero reports the raw dividend, not its magnitude
            res1_fin = '1;
            res2_fin = dvd_raw;
        end else begin
            res1_fin = quo_fix;
            res2_fin = rem_fix;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt     <= '0;
            op      <= '0;
            sgn1    <= 1'b0;
            sgn2    <= 1'b0;
            opb     <= '0;
            dvd_raw <= '0;
            acc     <= '0;
            rem     <= '0;
            res1    <= '0;
            res2    <= '0;
            dz      <= 1'b0;
            flags   <= 2'b01;
        end else if (accept) begin
            cnt     <= '0;
            op      <= bus.MCycleOp;
            sgn1    <= s1_in;
            sgn2    <= s2_in;
            dvd_raw <= bus.Operand1;
            rem     <= '0;
            opb     <= bus.MCycleOp[1] ? mag2 : mag1;
            acc     <= {{WIDTH{1'b0}}, (bus.MCycleOp[1] ? mag1 : mag2)};
        end else if (state == COMPUTE) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (op[1]) begin
                acc[WIDTH-1:0] <= quo_next;
                rem            <= rem_next;
            end else begin
                acc <= mul_next;
            end
            if (last) begin
                res1  <= res1_fin;
                res2  <= res2_fin;
                dz    <= div_zero;
                flags <= {res1_fin[WIDTH-1], res1_fin == '0};
            end
        end
    end

    assign bus.Result1   = res1;
    assign bus.Result2   = res2;
    assign bus.Busy      = busy;
    assign bus.Done      = done;
    assign bus.DivByZero = dz;
    assign bus.Flags     = flags;
endmodule

// File: tb/tb_mcycle_muldiv.sv
// Scoreboard bench for mcycle_muldiv: WIDTH=32 directed/random ops and a WIDTH=8 corner sweep.
module tb_mcycle_muldiv;
    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        dz;
        logic [1:0]  fl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t q32[$];
    exp_t q8[$];
    exp_t cur_e, prev_e;
    logic [7:0] cv [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h10, 8'h33, 8'h40,
                            8'h55, 8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC0, 8'hFE, 8'hFF};

    always #5 clk = ~clk;

    mcycle_muldiv_if #(.WIDTH(32)) b32 ();
    mcycle_muldiv_if #(.WIDTH(8))  b8 ();

    mcycle_muldiv #(.WIDTH(32)) u32 (.CLK(clk), .RESET(rst), .bus(b32));
    mcycle_muldiv #(.WIDTH(8))  u8  (.CLK(clk), .RESET(rst), .bus(b8));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [1:0] op,
                                   input logic [31:0] a_in, input logic [31:0] b_in);
        exp_t e;
        logic [31:0] msk, a, b;
        longint sa, sb, p, q, r;
        longint unsigned ua, ub;
        msk  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        a    = a_in & msk;
        b    = b_in & msk;
        sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        ua   = a;
        ub   = b;
        e.dz = 1'b0;
        if (!op[1]) begin
            p    = op[0] ? longint'(ua * ub) : sa * sb;
            e.r1 = 32'(p) & msk;
            e.r2 = 32'(p >> w) & msk;
        end else if (b == 0) begin
            e.r1 = msk;
            e.r2 = a;
            e.dz = 1'b1;
        end else if (!op[0]) begin
            q    = sa / sb;
            r    = sa % sb;
            e.r1 = 32'(q) & msk;
            e.r2 = 32'(r) & msk;
        end else begin
            e.r1 = 32'(ua / ub);
            e.r2 = 32'(ua % ub);
        end
        e.fl = {e.r1[w-1], e.r1 == 0};
        return e;
    endfunction

    // scoreboards pop on every Done
    always @(negedge clk) begin
        exp_t e;
        if (b32.Done) begin
            if (q32.size() == 0) chk("sb32_spurious_done", 1, 0);
            else begin
                e = q32.pop_front();
                chk("sb32_r1", b32.Result1, e.r1);
                chk("sb32_r2", b32.Result2, e.r2);
                chk("sb32_dz", b32.DivByZero, e.dz);
                chk("sb32_flags", b32.Flags, e.fl);
            end
        end
        if (b8.Done) begin
            if (q8.size() == 0) chk("sb8_spurious_done", 1, 0);
            else begin
                e = q8.pop_front();
                chk("sb8_r1", b8.Result1, e.r1);
                chk("sb8_r2", b8.Result2, e.r2);
                chk("sb8_dz", b8.DivByZero, e.dz);
                chk("sb8_flags", b8.Flags, e.fl);
            end
        end
    end

    // Drive a request, let it be accepted, then scramble the inputs; returns in cycle t+1.
    task automatic start32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        b32.Start = 1'b1; b32.MCycleOp = op; b32.Operand1 = a; b32.Operand2 = b;
        prev_e = cur_e;
        cur_e  = model(32, op, a, b);
        q32.push_back(cur_e);
        @(posedge clk); #1;
        b32.Start = 1'b0; b32.Operand1 = $urandom; b32.Operand2 = $urandom;
        b32.MCycleOp = 2'($urandom);
    endtask

    task automatic wait32(input string tag, input int n0);
        int n = n0;
        chk({tag, "_busy"}, b32.Busy, 1);
        while (!b32.Done && n < 60) begin @(posedge clk); #1; n++; end
        chk({tag, "_latency"}, n, 33);
        chk({tag, "_busy_in_done"}, b32.Busy, 0);
    endtask

    task automatic start8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        b8.Start = 1'b1; b8.MCycleOp = op; b8.Operand1 = a; b8.Operand2 = b;
        q8.push_back(model(8, op, {24'd0, a}, {24'd0, b}));
        @(posedge clk); #1;
        b8.Start = 1'b0; b8.Operand1 = 8'($urandom); b8.Operand2 = 8'($urandom);
    endtask

    task automatic wait8();
        int n = 1;
        while (!b8.Done && n < 30) begin @(posedge clk); #1; n++; end
        chk("w8_latency", n, 9);
    endtask

    initial begin
        int d;
        logic [31:0] ra, rb;
        rst = 1'b1;
        b32.Start = 1'b0; b32.MCycleOp = '0; b32.Operand1 = '0; b32.Operand2 = '0;
        b8.Start  = 1'b0; b8.MCycleOp  = '0; b8.Operand1  = '0; b8.Operand2  = '0;
        cur_e = model(32, 2'b01, 0, 0);
        repeat (3) @(posedge clk); #1;
        chk("rst_r1", b32.Result1, 0);
        chk("rst_r2", b32.Result2, 0);
        chk("rst_busy", b32.Busy, 0);
        chk("rst_done", b32.Done, 0);
        chk("rst_dz", b32.DivByZero, 0);
        chk("rst_flags", b32.Flags, 2'b01);
        rst = 1'b0;
        @(posedge clk); #1;

        start32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait32("umul", 1);
        chk("umul_hi", b32.Result2, 32'hFFFF_FFFE);
        chk("umul_lo", b32.Result1, 32'h0000_0001);
        chk("umul_flags", b32.Flags, 2'b00);
        @(posedge clk); #1;
        chk("done_one_cycle", b32.Done, 0);

        start32(2'b00, -32'sd3, 32'sd7);
        wait32("smul", 1);
        chk("smul_lo", b32.Result1, 32'hFFFF_FFEB);
        chk("smul_hi", b32.Result2, 32'hFFFF_FFFF);
        chk("smul_flags", b32.Flags, 2'b10);

        start32(2'b10, -32'sd7, 32'sd2);
        wait32("sdiv", 1);
        chk("sdiv_q", b32.Result1, 32'hFFFF_FFFD);
        chk("sdiv_r", b32.Result2, 32'hFFFF_FFFF);

        start32(2'b11, 32'd100, 32'd0);
        wait32("divzero", 1);
        chk("divzero_q", b32.Result1, 32'hFFFF_FFFF);
        chk("divzero_r", b32.Result2, 32'd100);
        chk("divzero_flag", b32.DivByZero, 1);

        start32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait32("minneg1", 1);
        chk("minneg1_q", b32.Result1, 32'h8000_0000);
        chk("minneg1_r", b32.Result2, 32'd0);
        chk("minneg1_dz", b32.DivByZero, 0);

        // Start mid-COMPUTE must be dropped, results held meanwhile
        start32(2'b00, 32'd1234, 32'd5678);
        repeat (9) @(posedge clk); #1;
        chk("hold_in_compute", b32.Result1, prev_e.r1);
        b32.Start = 1'b1; b32.Operand1 = 32'd9; b32.Operand2 = 32'd9;
        @(posedge clk); #1;
        b32.Start = 1'b0;
        wait32("busy_start", 11);
        chk("busy_start_r1", b32.Result1, 32'd7006652);
        @(posedge clk); #1;
        chk("no_queued_start", b32.Busy, 0);

        start32(2'b11, 32'd1000, 32'd7);
        wait32("b2b_a", 1);
        start32(2'b01, 32'd6, 32'd7);
        chk("b2b_done_low", b32.Done, 0);
        chk("b2b_hold", b32.Result1, prev_e.r1);
        wait32("b2b_b", 1);
        chk("b2b_r1", b32.Result1, 32'd42);

        // reset in COMPUTE cycle 15 aborts without a Done
        start32(2'b00, 32'h0000_DEAD, 32'h0000_BEEF);
        repeat (14) @(posedge clk); #1;
        rst = 1'b1;
        void'(q32.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", b32.Busy, 0);
        chk("abort_r1", b32.Result1, 0);
        chk("abort_flags", b32.Flags, 2'b01);
        d = 0;
        repeat (40) begin @(posedge clk); #1; d += int'(b32.Done); end
        chk("abort_no_done", d, 0);
        start32(2'b01, 32'd5, 32'd5);
        wait32("post_abort", 1);
        chk("post_abort_r1", b32.Result1, 32'd25);

        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            start32(2'($urandom), ra, rb);
            wait32("rand32", 1);
        end

        for (int o = 0; o < 4; o++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++) begin
                    start8(2'(o), cv[i], cv[j]);
                    wait8();
                end
        for (int k = 0; k < 200; k++) begin
            start8(2'($urandom), 8'($urandom), 8'($urandom));
            wait8();
        end

        @(posedge clk); #1;
        chk("sb32_drained", q32.size(), 0);
        chk("sb8_drained", q8.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
